mc_control: RTL

Multicycle control unit for the 32-bit MIPS-subset datapath; it is the successor to the single-cycle `control` decoder. It sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and stalls on a memory ready handshake. It also counts retired instructions. It sits between the instruction register opcode field and the shared-memory multicycle datapath: PC, IR, A/B/ALUOut/MDR registers, `regfile`, `alu`, `Alu_control`.

---
 rtl/mc_control_pkg.sv | 73 +++++++
 rtl/mc_control_outdec.sv | 87 ++++++++
 rtl/mc_control.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mc_control_pkg.sv
// Shared types and constants for the multicycle control unit.
// MC_CONTROL_JAL_EN enables the jal instruction (JAL state and link write).
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_EXEC_R    = 4'd2,
        ST_R_WB      = 4'd3,
        ST_MEM_ADDR  = 4'd4,
        ST_MEM_READ  = 4'd5,
        ST_MEM_WB    = 4'd6,
        ST_MEM_WRITE = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_IMM_EXEC  = 4'd9,
        ST_IMM_WB    = 4'd10,
        ST_JUMP      = 4'd11,
        ST_JAL       = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [1:0] ALUB_B       = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_req;
        logic       mem_we;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       jal_link;
    } ctrl_t;

    // Final state of each instruction: leaving it for FETCH retires the instruction.
    function automatic logic is_last_state(input state_e s);
        logic res;
        case (s)
            ST_R_WB, ST_MEM_WB, ST_MEM_WRITE,
            ST_BRANCH, ST_IMM_WB, ST_JUMP: res = 1'b1;
`ifdef MC_CONTROL_JAL_EN
            ST_JAL:                        res = 1'b1;
`endif
            default:                       res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mc_control_outdec.sv
// Combinational state -> control-word decode for mc_control.
// MC_CONTROL_JAL_EN adds the JAL control word; otherwise that encoding decodes as FETCH.
module mc_outdec
    import mc_pkg::*;
(
    input  state_e i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    function automatic ctrl_t fetch_word(input logic rdy);
        ctrl_t c;
        c           = '0;
        c.mem_req   = 1'b1;
        c.i_or_d    = 1'b0;
        c.alu_src_a = 1'b0;
        c.alu_src_b = ALUB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
        c.ir_write  = rdy;
        c.pc_write  = rdy;
        return c;
    endfunction

    // Moore decode; FETCH alone gates its IR/PC loads on the memory handshake.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: o_ctrl = fetch_word(i_mem_ready);
            ST_DECODE: begin
                o_ctrl.alu_src_b = ALUB_IMM_SH2;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            ST_EXEC_R: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUB_B;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            ST_MEM_ADDR, ST_IMM_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_READ: begin
                o_ctrl.mem_req = 1'b1;
                o_ctrl.i_or_d  = 1'b1;
            end
            ST_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                o_ctrl.mem_req = 1'b1;
                o_ctrl.mem_we  = 1'b1;
                o_ctrl.i_or_d  = 1'b1;
            end
            ST_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = ALUB_B;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_IMM_WB: begin
                o_ctrl.reg_write = 1'b1;
            end
            ST_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef MC_CONTROL_JAL_EN
            ST_JAL: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.jal_link  = 1'b1;
            end
`endif
            default: o_ctrl = fetch_word(i_mem_ready);
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS-subset control FSM with memory-ready stalls and a retired counter.
// MC_CONTROL_JAL_EN enables jal; when undefined opcode 000011 is flagged illegal.
module mc_control
    import mc_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                ir_write,
    output logic                i_or_d,
    output logic                mem_req,
    output logic                mem_we,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                jal_link,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired,
    output logic [3:0]          state
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e              r_state;
    state_e              w_next;
    logic [OPCODE_W-1:0] r_opcode;
    logic                r_illegal;
    logic                w_illegal;
    logic                w_retire;
    logic [CNT_W-1:0]    r_retired;
    ctrl_t               w_ctrl;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; the live opcode is only consulted in DECODE
    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (mem_ready) w_next = ST_DECODE;
                else           w_next = ST_FETCH;
            end
            ST_DECODE: begin
                if (opcode == OPCODE_W'(OP_RTYPE)) begin
                    w_next = ST_EXEC_R;
                end else if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW)) begin
                    w_next = ST_MEM_ADDR;
                end else if (opcode == OPCODE_W'(OP_BEQ)) begin
                    w_next = ST_BRANCH;
                end else if (opcode == OPCODE_W'(OP_ADDI)) begin
                    w_next = ST_IMM_EXEC;
                end else if (opcode == OPCODE_W'(OP_J)) begin
                    w_next = ST_JUMP;
`ifdef MC_CONTROL_JAL_EN
                end else if (opcode == OPCODE_W'(OP_JAL)) begin
                    w_next = ST_JAL;
`endif
                end else begin
                    w_next    = ST_FETCH;
                    w_illegal = 1'b1;
                end
            end
            ST_EXEC_R:   w_next = ST_R_WB;
            ST_MEM_ADDR: begin
                if (r_opcode == OPCODE_W'(OP_SW)) w_next = ST_MEM_WRITE;
                else                              w_next = ST_MEM_READ;
            end
            ST_MEM_READ: begin
                if (mem_ready) w_next = ST_MEM_WB;
                else           w_next = ST_MEM_READ;
            end
            ST_MEM_WRITE: begin
                if (mem_ready) w_next = ST_FETCH;
                else           w_next = ST_MEM_WRITE;
            end
            ST_IMM_EXEC: w_next = ST_IMM_WB;
            default:     w_next = ST_FETCH;
        endcase
    end

    assign w_retire = (w_next == ST_FETCH) && is_last_state(r_state);

    // Opcode latch, illegal pulse and retired-instruction counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opcode  <= '0;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            if (r_state == ST_DECODE) r_opcode <= opcode;
            else                      r_opcode <= r_opcode;
            r_illegal <= w_illegal;
            if (w_retire) r_retired <= r_retired + CNT_ONE;
            else          r_retired <= r_retired;
        end
    end

    mc_outdec u_outdec (
        .i_state     (r_state),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign ir_write      = w_ctrl.ir_write;
    assign i_or_d        = w_ctrl.i_or_d;
    assign mem_req       = w_ctrl.mem_req;
    assign mem_we        = w_ctrl.mem_we;
    assign reg_write     = w_ctrl.reg_write;
    assign reg_dst       = w_ctrl.reg_dst;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_op        = w_ctrl.alu_op;
    assign pc_source     = w_ctrl.pc_source;
    assign jal_link      = w_ctrl.jal_link;
    assign illegal       = r_illegal;
    assign retired       = r_retired;
    assign state         = r_state;

endmodule
